// File: rtl/comp_wide_serial.sv
// Byte-serial wide magnitude comparator, MSB byte first, with registered gt/lt/eq cascade.
// Optional macro COMP_EARLY_EXIT_EN: finish as soon as a byte decides the result.
module comp_wide_serial #(
    parameter int NBYTES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       byte_valid,
    input  logic [7:0] a_byte,
    input  logic [7:0] b_byte,
    output logic       busy,
    output logic       done,
    output logic       agtb,
    output logic       altb,
    output logic       aeqb
);

    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    // Cascade and result vectors are packed as {gt, lt, eq}
    logic [2:0]    casc, casc_nxt;
    logic [2:0]    res, res_nxt;
    logic          done_nxt;
    logic [2:0]    casc_upd;
    logic          finish;

    function automatic logic [2:0] cmp_byte(input logic [7:0] a, input logic [7:0] b);
        return {a > b, a < b, a == b};
    endfunction

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        casc_nxt  = casc;
        res_nxt   = res;
        done_nxt  = 1'b0;
        casc_upd  = casc[0] ? cmp_byte(a_byte, b_byte) : casc;
`ifdef COMP_EARLY_EXIT_EN
        finish    = (cnt == LAST_IDX) || (casc[0] && (a_byte != b_byte));
`else
        finish    = (cnt == LAST_IDX);
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                    casc_nxt  = 3'b001;
                end
            end
            RUN: begin
                if (byte_valid) begin
                    casc_nxt = casc_upd;
                    cnt_nxt  = cnt + 1'b1;
                    if (finish) begin
                        state_nxt = IDLE;
                        res_nxt   = casc_upd;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            casc  <= 3'b001;
            res   <= 3'b000;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            casc  <= casc_nxt;
            res   <= res_nxt;
            done  <= done_nxt;
        end
    end

    assign busy = (state == RUN);
    assign agtb = res[2];
    assign altb = res[1];
    assign aeqb = res[0];

endmodule

// File: tb/tb_comp_wide_serial.sv
// Directed, table-driven bench for comp_wide_serial with NBYTES=4.
// Honors COMP_EARLY_EXIT_EN when computing expected latencies.
module tb_comp_wide_serial;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       byte_valid;
    logic [7:0] a_byte;
    logic [7:0] b_byte;
    logic       busy, done, agtb, altb, aeqb;

    int checks = 0;
    int errors = 0;

    comp_wide_serial #(.NBYTES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid),
        .a_byte(a_byte), .b_byte(b_byte), .busy(busy), .done(done),
        .agtb(agtb), .altb(altb), .aeqb(aeqb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          gap_pos;
        int          gap_len;
        logic [2:0]  flags;
        int          edges_full;
        int          edges_early;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] flags_now();
        return {agtb, altb, aeqb};
    endfunction

    // Streams a and b MSB first, optionally inserting a byte_valid gap after gap_pos bytes.
    // Returns the number of edges from the start edge to the edge that raised done.
    task automatic do_cmp(input logic [31:0] a, input logic [31:0] b,
                          input int gap_pos, input int gap_len,
                          input bit hold_start, input bit skip_start,
                          output int edges, output logic [2:0] res);
        logic [2:0] prev;
        int idx, gap_rem;
        bit gapped;
        prev = flags_now();
        if (!skip_start) begin
            start = 1'b1;
            byte_valid = 1'b1;
            a_byte = 8'h00;
            b_byte = 8'hFF;
            step();
        end
        start = hold_start;
        chk("busy_after_start", {31'b0, busy}, 1);
        edges = 0;
        idx = 0;
        gap_rem = 0;
        gapped = 0;
        while (!done && edges < 40) begin
            if (!gapped && idx == gap_pos && gap_len > 0) begin
                gap_rem = gap_len;
                gapped = 1;
            end
            if (gap_rem > 0) begin
                byte_valid = 1'b0;
                a_byte = 8'h00;
                b_byte = 8'hFF;
                gap_rem--;
            end else begin
                byte_valid = 1'b1;
                a_byte = (idx < 4) ? a[31 - 8*idx -: 8] : 8'h00;
                b_byte = (idx < 4) ? b[31 - 8*idx -: 8] : 8'h00;
            end
            step();
            edges++;
            if (byte_valid) idx++;
            if (!done) begin
                chk("flags_hold_in_run", {29'b0, flags_now()}, {29'b0, prev});
                chk("busy_in_run", {31'b0, busy}, 1);
            end
        end
        if (!done) begin
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", edges);
        end
        byte_valid = 1'b0;
        res = flags_now();
    endtask

    vec_t vecs[7];

    initial begin
        int edges;
        int exp_edges;
        logic [2:0] res;
        logic [2:0] prev;

        // {a, b, gap_pos, gap_len, {gt,lt,eq}, edges without early exit, edges with}
        vecs[0] = '{32'h12345678, 32'h12345678, 0, 0, 3'b001, 4, 4};
        vecs[1] = '{32'hFF000000, 32'h00FFFFFF, 0, 0, 3'b100, 4, 1};
        vecs[2] = '{32'hAABBCC01, 32'hAABBCC02, 0, 0, 3'b010, 4, 4};
        vecs[3] = '{32'h00000000, 32'h00000000, 2, 3, 3'b001, 7, 7};
        vecs[4] = '{32'h12340000, 32'h12350000, 0, 0, 3'b010, 4, 2};
        vecs[5] = '{32'h80000000, 32'h7FFFFFFF, 0, 0, 3'b100, 4, 1};
        vecs[6] = '{32'h00000001, 32'h00000000, 1, 2, 3'b100, 6, 6};

        rst_n = 1'b0;
        start = 1'b0;
        byte_valid = 1'b0;
        a_byte = 8'h00;
        b_byte = 8'h00;
        step();
        step();
        rst_n = 1'b1;
        chk("reset_busy", {31'b0, busy}, 0);
        chk("reset_done", {31'b0, done}, 0);
        chk("reset_flags", {29'b0, flags_now()}, 0);

        // byte_valid alone in IDLE must not start anything
        byte_valid = 1'b1;
        a_byte = 8'h01;
        b_byte = 8'h02;
        step();
        byte_valid = 1'b0;
        chk("idle_bv_busy", {31'b0, busy}, 0);
        chk("idle_bv_done", {31'b0, done}, 0);

        for (int i = 0; i < 7; i++) begin
`ifdef COMP_EARLY_EXIT_EN
            exp_edges = vecs[i].edges_early;
`else
            exp_edges = vecs[i].edges_full;
`endif
            do_cmp(vecs[i].a, vecs[i].b, vecs[i].gap_pos, vecs[i].gap_len, 0, 0, edges, res);
            chk($sformatf("vec%0d_flags", i), {29'b0, res}, {29'b0, vecs[i].flags});
            chk($sformatf("vec%0d_latency", i), edges, exp_edges);
            chk($sformatf("vec%0d_busy_at_done", i), {31'b0, busy}, 0);
            step();
            chk($sformatf("vec%0d_done_pulse", i), {31'b0, done}, 0);
            chk($sformatf("vec%0d_flags_stable", i), {29'b0, flags_now()}, {29'b0, vecs[i].flags});
        end

        // Reset in the middle of a comparison: no done, all outputs cleared
        start = 1'b1;
        step();
        start = 1'b0;
        byte_valid = 1'b1;
        a_byte = 8'h12;
        b_byte = 8'h12;
        step();
        step();
        byte_valid = 1'b0;
        rst_n = 1'b0;
        step();
        chk("midrst_busy", {31'b0, busy}, 0);
        chk("midrst_done", {31'b0, done}, 0);
        chk("midrst_flags", {29'b0, flags_now()}, 0);
        rst_n = 1'b1;
        step();
        step();
        chk("midrst_no_done", {31'b0, done}, 0);
        do_cmp(32'hAABBCC01, 32'hAABBCC02, 0, 0, 0, 0, edges, res);
        chk("after_rst_flags", {29'b0, res}, 32'h2);
        chk("after_rst_latency", edges, 4);

        // start held high throughout RUN and into the done cycle
        do_cmp(32'h80000000, 32'h7FFFFFFF, 0, 0, 1, 0, edges, res);
        chk("hold_start_flags", {29'b0, res}, 32'h4);
`ifdef COMP_EARLY_EXIT_EN
        chk("hold_start_latency", edges, 1);
`else
        chk("hold_start_latency", edges, 4);
`endif
        prev = res;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("b2b_busy", {31'b0, busy}, 1);
        chk("b2b_done_low", {31'b0, done}, 0);
        chk("b2b_flags_hold", {29'b0, flags_now()}, {29'b0, prev});
        do_cmp(32'h01020304, 32'h01020305, 0, 0, 0, 1, edges, res);
        chk("b2b_flags", {29'b0, res}, 32'h2);
        chk("b2b_latency", edges, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
